// File: rtl/jstk_conditioner.sv
// Joystick conditioner: zone hysteresis and tick debounce per axis and button,
// producing one-clock move pulses with auto-repeat and a one-clock press pulse.

module jstk_axis #(
    parameter logic [9:0] LO_TH     = 10'd300,
    parameter logic [9:0] HI_TH     = 10'd724,
    parameter logic [9:0] HYST      = 10'd40,
    parameter logic [3:0] DEB_TICKS = 4'd5,
    parameter logic [7:0] REP_FIRST = 8'd50,
    parameter logic [7:0] REP_RATE  = 8'd20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tick,
    input  logic [9:0] samp,
    output logic       pulse_neg,
    output logic       pulse_pos,
    output logic [1:0] state_dbg
);
    localparam logic [1:0]  Z_CENTER = 2'd0;
    localparam logic [1:0]  Z_NEG    = 2'd1;
    localparam logic [1:0]  Z_POS    = 2'd2;
    localparam logic [10:0] NEG_EXIT = {1'b0, LO_TH} + {1'b0, HYST};
    localparam logic [9:0]  POS_EXIT = HI_TH - HYST;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FIRST = 2'd1, ST_REPEAT = 2'd2} state_e;

    state_e     state_q, state_d;
    logic [1:0] zone_raw;
    logic [1:0] cand_q, cand_d, acc_q, acc_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rep_q, rep_d;
    logic       pulse_neg_q, pulse_neg_d, pulse_pos_q, pulse_pos_d;
    logic       fire;

    // Leaving a zone needs the value to clear the threshold by HYST.
    always_comb begin
        zone_raw = Z_CENTER;
        if (samp < LO_TH)                                        zone_raw = Z_NEG;
        else if (samp > HI_TH)                                   zone_raw = Z_POS;
        else if (acc_q == Z_NEG && {1'b0, samp} < NEG_EXIT)      zone_raw = Z_NEG;
        else if (acc_q == Z_POS && samp > POS_EXIT)              zone_raw = Z_POS;
    end

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        if (!en) begin
            cand_d = Z_CENTER;
            cnt_d  = 4'd0;
            acc_d  = Z_CENTER;
        end else if (zone_raw != cand_q) begin
            cand_d = zone_raw;
            cnt_d  = 4'd0;
        end else if (tick && cnt_q != DEB_TICKS) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == DEB_TICKS) acc_d = cand_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q <= Z_CENTER;
            cnt_q  <= 4'd0;
            acc_q  <= Z_CENTER;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rep_q       <= 8'd0;
            pulse_neg_q <= 1'b0;
            pulse_pos_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rep_q       <= rep_d;
            pulse_neg_q <= pulse_neg_d;
            pulse_pos_q <= pulse_pos_d;
        end
    end

    // The FSM reacts to the acceptance in the same edge, so pulses lag the tick by one clk.
    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        if (!en) begin
            state_d = ST_IDLE;
            rep_d   = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc_d != Z_CENTER) begin
                        state_d = ST_FIRST;
                        rep_d   = REP_FIRST;
                    end
                end
                default: begin
                    if (acc_d == Z_CENTER) begin
                        state_d = ST_IDLE;
                        rep_d   = 8'd0;
                    end else if (acc_d != acc_q) begin
                        state_d = ST_FIRST;
                        rep_d   = REP_FIRST;
                    end else if (tick) begin
                        if (rep_q <= 8'd1) begin
                            state_d = ST_REPEAT;
                            rep_d   = REP_RATE;
                        end else begin
                            rep_d = rep_q - 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        fire = 1'b0;
        if (en) begin
            case (state_q)
                ST_IDLE: fire = (acc_d != Z_CENTER);
                default: fire = (acc_d != Z_CENTER) &&
                                ((acc_d != acc_q) || (tick && rep_q <= 8'd1));
            endcase
        end
        pulse_neg_d = fire && (acc_d == Z_NEG);
        pulse_pos_d = fire && (acc_d == Z_POS);
    end

    assign pulse_neg = pulse_neg_q;
    assign pulse_pos = pulse_pos_q;
    assign state_dbg = state_q;
endmodule

module jstk_conditioner #(
    parameter logic [9:0] LO_TH     = 10'd300,
    parameter logic [9:0] HI_TH     = 10'd724,
    parameter logic [9:0] HYST      = 10'd40,
    parameter logic [3:0] DEB_TICKS = 4'd5,
    parameter logic [7:0] REP_FIRST = 8'd50,
    parameter logic [7:0] REP_RATE  = 8'd20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tick,
    input  logic [9:0] raw_x,
    input  logic [9:0] raw_y,
    input  logic       raw_valid,
    input  logic       raw_btn,
    output logic [3:0] jstkPos,
    output logic       jstkPress,
    output logic [3:0] dbg_state
);
    logic [9:0] samp_x_q, samp_x_d, samp_y_q, samp_y_d;
    logic       samp_btn_q, samp_btn_d;
    logic       btn_cand_q, btn_cand_d, btn_acc_q, btn_acc_d;
    logic [3:0] btn_cnt_q, btn_cnt_d;
    logic       press_q, press_d;
    logic       x_neg, x_pos, y_neg, y_pos;
    logic [1:0] x_state, y_state;

    // Sampling ignores en so a held stick is seen immediately on re-enable.
    always_comb begin
        samp_x_d   = raw_valid ? raw_x   : samp_x_q;
        samp_y_d   = raw_valid ? raw_y   : samp_y_q;
        samp_btn_d = raw_valid ? raw_btn : samp_btn_q;
    end

    always_comb begin
        btn_cand_d = btn_cand_q;
        btn_cnt_d  = btn_cnt_q;
        btn_acc_d  = btn_acc_q;
        if (!en) begin
            btn_cand_d = 1'b0;
            btn_cnt_d  = 4'd0;
            btn_acc_d  = 1'b0;
        end else if (samp_btn_q != btn_cand_q) begin
            btn_cand_d = samp_btn_q;
            btn_cnt_d  = 4'd0;
        end else if (tick && btn_cnt_q != DEB_TICKS) begin
            btn_cnt_d = btn_cnt_q + 4'd1;
            if (btn_cnt_d == DEB_TICKS) btn_acc_d = btn_cand_q;
        end
        press_d = en && btn_acc_d && !btn_acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_x_q   <= 10'd512;
            samp_y_q   <= 10'd512;
            samp_btn_q <= 1'b0;
            btn_cand_q <= 1'b0;
            btn_cnt_q  <= 4'd0;
            btn_acc_q  <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            samp_x_q   <= samp_x_d;
            samp_y_q   <= samp_y_d;
            samp_btn_q <= samp_btn_d;
            btn_cand_q <= btn_cand_d;
            btn_cnt_q  <= btn_cnt_d;
            btn_acc_q  <= btn_acc_d;
            press_q    <= press_d;
        end
    end

    jstk_axis #(
        .LO_TH(LO_TH), .HI_TH(HI_TH), .HYST(HYST), .DEB_TICKS(DEB_TICKS),
        .REP_FIRST(REP_FIRST), .REP_RATE(REP_RATE)
    ) u_axis_x (
        .clk(clk), .rst(rst), .en(en), .tick(tick), .samp(samp_x_q),
        .pulse_neg(x_neg), .pulse_pos(x_pos), .state_dbg(x_state)
    );

    jstk_axis #(
        .LO_TH(LO_TH), .HI_TH(HI_TH), .HYST(HYST), .DEB_TICKS(DEB_TICKS),
        .REP_FIRST(REP_FIRST), .REP_RATE(REP_RATE)
    ) u_axis_y (
        .clk(clk), .rst(rst), .en(en), .tick(tick), .samp(samp_y_q),
        .pulse_neg(y_neg), .pulse_pos(y_pos), .state_dbg(y_state)
    );

    assign jstkPos   = {x_pos, x_neg, y_neg, y_pos};
    assign jstkPress = press_q;
    assign dbg_state = {y_state, x_state};
endmodule

// File: tb/tb_jstk_conditioner.sv
// Directed bench for jstk_conditioner: table of input segments with expected
// pulse counts, plus exact-timing sequences for repeat, bounce, enable and reset.

module tb_jstk_conditioner;
    localparam int TICK_GAP = 8;

    logic       clk, rst, en, tick, raw_valid, raw_btn;
    logic [9:0] raw_x, raw_y;
    logic [3:0] jstk_pos, dbg_state;
    logic       jstk_press;

    jstk_conditioner dut (
        .clk(clk), .rst(rst), .en(en), .tick(tick),
        .raw_x(raw_x), .raw_y(raw_y), .raw_valid(raw_valid), .raw_btn(raw_btn),
        .jstkPos(jstk_pos), .jstkPress(jstk_press), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         en;
        logic [9:0] x;
        logic [9:0] y;
        bit         btn;
        bit         valid;
        int         ticks;
        int         e_up, e_dn, e_lf, e_rt, e_pr;
    } row_t;

    row_t rows[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   tick_num = 0;
    int   pulse_cnt[5];
    int   last_tick[5];
    int   dual_cnt = 0;
    bit   seen_0101 = 1'b0;

    // Index 0..3 follow jstkPos bits (up, down, left, right); 4 is the press.
    always @(negedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (jstk_pos[b]) begin
                pulse_cnt[b]++;
                last_tick[b] = tick_num;
            end
        end
        if (jstk_press) begin
            pulse_cnt[4]++;
            last_tick[4] = tick_num;
        end
        if ((jstk_pos[0] && jstk_pos[1]) || (jstk_pos[2] && jstk_pos[3])) dual_cnt++;
        if (jstk_pos == 4'b0101) seen_0101 = 1'b1;
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input bit e, input logic [9:0] x, input logic [9:0] y,
                          input bit b, input bit v);
        en = e; raw_x = x; raw_y = y; raw_btn = b; raw_valid = v;
        cycles(2);
    endtask

    task automatic run_ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            tick_num++;
            cycles(1);
            tick = 1'b0;
            cycles(TICK_GAP - 1);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_row(input bit e, input int x, input int y, input bit b, input bit v,
                           input int t, input int up, input int dn, input int lf,
                           input int rt, input int pr);
        row_t r;
        r.en = e; r.x = x[9:0]; r.y = y[9:0]; r.btn = b; r.valid = v; r.ticks = t;
        r.e_up = up; r.e_dn = dn; r.e_lf = lf; r.e_rt = rt; r.e_pr = pr;
        rows.push_back(r);
    endtask

    initial begin
        row_t r;
        int   base[5];
        int   start;

        //      en  x    y    btn v ticks up dn lf rt pr
        add_row(1, 100, 512, 0, 1, 3,    0, 0, 0, 0, 0);
        add_row(1, 512, 512, 0, 1, 10,   0, 0, 0, 0, 0);
        add_row(1, 100, 512, 0, 1, 5,    0, 0, 1, 0, 0);
        add_row(1, 320, 512, 0, 1, 20,   0, 0, 0, 0, 0);
        add_row(1, 290, 512, 0, 1, 20,   0, 0, 0, 0, 0);
        add_row(1, 339, 512, 0, 1, 10,   0, 0, 1, 0, 0);
        add_row(1, 340, 512, 0, 1, 5,    0, 0, 0, 0, 0);
        add_row(1, 320, 512, 0, 1, 30,   0, 0, 0, 0, 0);
        add_row(1, 100, 512, 0, 1, 5,    0, 0, 1, 0, 0);
        add_row(1, 900, 512, 0, 1, 5,    0, 0, 0, 1, 0);
        add_row(1, 900, 512, 0, 1, 49,   0, 0, 0, 0, 0);
        add_row(1, 900, 512, 0, 1, 1,    0, 0, 0, 1, 0);
        add_row(1, 900, 512, 0, 1, 19,   0, 0, 0, 0, 0);
        add_row(1, 900, 512, 0, 1, 1,    0, 0, 0, 1, 0);
        add_row(1, 685, 512, 0, 1, 20,   0, 0, 0, 1, 0);
        add_row(1, 684, 512, 0, 1, 5,    0, 0, 0, 0, 0);
        add_row(1, 700, 512, 0, 1, 10,   0, 0, 0, 0, 0);
        add_row(1, 725, 512, 0, 1, 5,    0, 0, 0, 1, 0);
        add_row(1, 512, 512, 0, 1, 5,    0, 0, 0, 0, 0);
        add_row(1, 300, 512, 0, 1, 10,   0, 0, 0, 0, 0);
        add_row(1, 299, 512, 0, 1, 5,    0, 0, 1, 0, 0);
        add_row(1, 512, 512, 0, 1, 5,    0, 0, 0, 0, 0);
        add_row(1, 100, 512, 0, 0, 10,   0, 0, 0, 0, 0);
        add_row(1, 100, 512, 0, 1, 5,    0, 0, 1, 0, 0);
        add_row(1, 512, 512, 0, 1, 5,    0, 0, 0, 0, 0);
        add_row(1, 512, 100, 0, 1, 5,    0, 1, 0, 0, 0);
        add_row(1, 512, 900, 0, 1, 5,    1, 0, 0, 0, 0);
        add_row(1, 512, 512, 0, 1, 5,    0, 0, 0, 0, 0);
        add_row(1, 512, 512, 1, 1, 4,    0, 0, 0, 0, 0);
        add_row(1, 512, 512, 0, 1, 5,    0, 0, 0, 0, 0);
        add_row(1, 512, 512, 1, 1, 5,    0, 0, 0, 0, 1);
        add_row(1, 512, 512, 1, 1, 60,   0, 0, 0, 0, 0);
        add_row(1, 512, 512, 0, 1, 10,   0, 0, 0, 0, 0);
        add_row(1, 512, 512, 1, 1, 5,    0, 0, 0, 0, 1);
        add_row(1, 512, 512, 0, 1, 5,    0, 0, 0, 0, 0);
        add_row(0, 100, 512, 0, 1, 10,   0, 0, 0, 0, 0);
        add_row(1, 100, 512, 0, 1, 5,    0, 0, 1, 0, 0);
        add_row(1, 512, 512, 0, 1, 5,    0, 0, 0, 0, 0);

        // Reset overrides en, tick and raw_valid; samples must come back as 512/0.
        rst = 1'b1; en = 1'b1; tick = 1'b1; raw_valid = 1'b1;
        raw_x = 10'd100; raw_y = 10'd900; raw_btn = 1'b1;
        cycles(3);
        check("rst_pos", int'(jstk_pos), 0);
        check("rst_press", int'(jstk_press), 0);
        check("rst_state", int'(dbg_state), 0);
        rst = 1'b0; tick = 1'b0; raw_valid = 1'b0;
        cycles(2);
        run_ticks(10);
        check("rst_sample_left", pulse_cnt[2], 0);
        check("rst_sample_up", pulse_cnt[0], 0);
        check("rst_sample_press", pulse_cnt[4], 0);

        // Held left: first pulse one clk after 5th tick, then +50, then every 20.
        set_in(1, 100, 512, 0, 1);
        start = tick_num;
        base[2] = pulse_cnt[2];
        run_ticks(4);
        tick = 1'b1; tick_num++;
        cycles(1);
        tick = 1'b0;
        check("first_pulse_cycle", int'(jstk_pos), 4);
        cycles(1);
        check("first_pulse_width", int'(jstk_pos), 0);
        cycles(TICK_GAP - 2);
        run_ticks(50);
        check("first_repeat_tick", last_tick[2] - start, 55);
        run_ticks(20);
        check("second_repeat_tick", last_tick[2] - start, 75);
        check("repeat_count", pulse_cnt[2] - base[2], 3);
        set_in(1, 512, 512, 0, 1);
        run_ticks(5);

        for (int i = 0; i < rows.size(); i++) begin
            r = rows[i];
            for (int b = 0; b < 5; b++) base[b] = pulse_cnt[b];
            set_in(r.en, r.x, r.y, r.btn, r.valid);
            run_ticks(r.ticks);
            cycles(2);
            check($sformatf("row%0d_up", i),    pulse_cnt[0] - base[0], r.e_up);
            check($sformatf("row%0d_down", i),  pulse_cnt[1] - base[1], r.e_dn);
            check($sformatf("row%0d_left", i),  pulse_cnt[2] - base[2], r.e_lf);
            check($sformatf("row%0d_right", i), pulse_cnt[3] - base[3], r.e_rt);
            check($sformatf("row%0d_press", i), pulse_cnt[4] - base[4], r.e_pr);
        end

        // Button bounce for 8 ticks, then held: one press 5 ticks after settling.
        base[4] = pulse_cnt[4];
        for (int i = 0; i < 8; i++) begin
            set_in(1, 512, 512, (i % 2 == 0), 1);
            run_ticks(1);
        end
        check("bounce_no_press", pulse_cnt[4] - base[4], 0);
        set_in(1, 512, 512, 1, 1);
        start = tick_num;
        run_ticks(5);
        check("bounce_press_count", pulse_cnt[4] - base[4], 1);
        check("bounce_press_tick", last_tick[4] - start, 5);
        set_in(1, 512, 512, 0, 1);
        run_ticks(10);
        check("release_no_press", pulse_cnt[4] - base[4], 1);

        // Diagonal, then en low with repeats pending, then re-enable with stick held.
        seen_0101 = 1'b0;
        set_in(1, 100, 900, 0, 1);
        run_ticks(5);
        check("diag_0101", int'(seen_0101), 1);
        run_ticks(30);
        en = 1'b0;
        cycles(1);
        check("en_low_pos", int'(jstk_pos), 0);
        check("en_low_state", int'(dbg_state), 0);
        for (int b = 0; b < 5; b++) base[b] = pulse_cnt[b];
        run_ticks(60);
        check("en_low_left", pulse_cnt[2] - base[2], 0);
        check("en_low_up", pulse_cnt[0] - base[0], 0);
        seen_0101 = 1'b0;
        en = 1'b1;
        cycles(2);
        start = tick_num;
        run_ticks(5);
        check("reen_0101", int'(seen_0101), 1);
        check("reen_left_tick", last_tick[2] - start, 5);
        check("reen_up_tick", last_tick[0] - start, 5);
        set_in(1, 512, 512, 0, 1);
        run_ticks(5);

        // Reset mid-repeat: pending repeats vanish, fresh debounce after release.
        set_in(1, 100, 512, 0, 1);
        run_ticks(70);
        rst = 1'b1;
        cycles(1);
        check("mid_rst_pos", int'(jstk_pos), 0);
        check("mid_rst_state", int'(dbg_state), 0);
        base[2] = pulse_cnt[2];
        run_ticks(3);
        rst = 1'b0;
        cycles(2);
        start = tick_num;
        run_ticks(4);
        check("post_rst_quiet", pulse_cnt[2] - base[2], 0);
        run_ticks(1);
        check("post_rst_count", pulse_cnt[2] - base[2], 1);
        check("post_rst_tick", last_tick[2] - start, 5);

        check("no_opposite_pulses", dual_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
